// File: rtl/regfile_write_port.sv
// regfile_write_port
//   Write side of the 32-entry register file. It decodes the write address into
//   a one-hot enable and updates the storage. Register 31 (XZR) always reads as
//   zero. A clear request walks a counter across registers 0..30 and zeroes one
//   register per cycle. The whole array is exported flattened so the read-port
//   muxes can select from it.
//
// Ports
//   clk           rising-edge clock
//   reset_n       synchronous, active-low reset
//   wr_valid      write request present
//   wr_ready      a write can be accepted this cycle (IDLE and out of reset)
//   wr_addr       destination register index
//   wr_data       write data
//   clear_req     request to zero all registers
//   clear_busy    clear sequence in progress
//   wr_en_onehot  one-hot of the register written in the previous cycle
//   wr_done       pulse: a write was accepted in the previous cycle
//   regs_flat     register array, reg i at bits [i*WIDTH +: WIDTH]
module regfile_write_port #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [4:0]             wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   clear_req,
  output logic                   clear_busy,
  output logic [31:0]            wr_en_onehot,
  output logic                   wr_done,
  output logic [NREGS*WIDTH-1:0] regs_flat
);

  localparam logic [4:0] XZR_IDX  = 5'd31;
  localparam logic [4:0] LAST_CLR = 5'd30;

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [31:0]      onehot_q, onehot_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             accept;

  assign wr_ready   = (state_q == IDLE) && reset_n;
  assign clear_busy = (state_q == CLEAR);
  assign accept     = wr_valid && wr_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = '0;
    done_d   = 1'b0;
    regs_d   = regs_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          done_d = 1'b1;
          // Writes to XZR are accepted but leave storage and the enable untouched.
          if (wr_addr != XZR_IDX) begin
            regs_d[wr_addr] = wr_data;
            for (int i = 0; i < 32; i++) begin
              onehot_d[i] = (wr_addr == 5'(i));
            end
          end
        end
        // A write accepted on the same edge is zeroed later by the sweep.
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        onehot_d      = 32'd1 << cnt_q;
        if (cnt_q == LAST_CLR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    regs_d[XZR_IDX] = '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      done_q   <= done_d;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign wr_en_onehot = onehot_q;
  assign wr_done      = done_q;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
  end

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [4:0]    wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic          clear_req = 1'b0;
  logic          clear_busy;
  logic [31:0]   wr_en_onehot;
  logic          wr_done;
  logic [32*W-1:0] regs_flat;

  regfile_write_port #(.WIDTH(W), .NREGS(32)) dut (
    .clk(clk), .reset_n(reset_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clear_req(clear_req),
    .clear_busy(clear_busy), .wr_en_onehot(wr_en_onehot), .wr_done(wr_done),
    .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] oh;
    logic        done;
    logic        busy;
    logic        ready;
  } exp_t;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [63:0] d;
    logic [31:0] oh;
    logic        done;
  } vec_t;

  exp_t        exp_q[$];
  logic [W-1:0] model [32];
  vec_t        tbl [8];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_regs(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < 32; i++) begin
      if (bad < 0 && regs_flat[i*W +: W] !== model[i]) bad = i;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s reg%0d actual=%0h required=%0h", name, bad,
               regs_flat[bad*W +: W], model[bad]);
    end
  endtask

  // Apply one cycle of stimulus, queue the outputs expected after the edge,
  // update the register model, then compare once the edge has passed.
  task automatic drive(input logic rn, input logic v, input logic [4:0] a,
                       input logic [W-1:0] d, input logic c,
                       input logic [31:0] eoh, input logic edone,
                       input logic ebusy, input logic eready, input string tag);
    exp_t e;
    reset_n   = rn;
    wr_valid  = v;
    wr_addr   = a;
    wr_data   = d;
    clear_req = c;
    e.oh = eoh; e.done = edone; e.busy = ebusy; e.ready = eready;
    exp_q.push_back(e);
    if (!rn) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (edone) begin
      if (a != 5'd31) model[a] = d;
    end else begin
      for (int i = 0; i < 32; i++) if (eoh[i]) model[i] = '0;
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " wr_en_onehot"}, 64'(wr_en_onehot), 64'(e.oh));
      chk({tag, " wr_done"},      64'(wr_done),      64'(e.done));
      chk({tag, " clear_busy"},   64'(clear_busy),   64'(e.busy));
      chk({tag, " wr_ready"},     64'(wr_ready),     64'(e.ready));
      chk_regs({tag, " regs"});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;

    tbl[0] = '{1'b1, 5'd5,  64'hDEAD_BEEF_0000_0001, 32'h0000_0020, 1'b1};
    tbl[1] = '{1'b0, 5'd5,  64'h0,                   32'h0,         1'b0};
    tbl[2] = '{1'b1, 5'd31, 64'h0000_0000_0000_0123, 32'h0,         1'b1};
    tbl[3] = '{1'b1, 5'd7,  64'hAAAA_AAAA_AAAA_AAAA, 32'h0000_0080, 1'b1};
    tbl[4] = '{1'b1, 5'd7,  64'h5555_5555_5555_5555, 32'h0000_0080, 1'b1};
    tbl[5] = '{1'b1, 5'd0,  64'h0000_0000_0000_0001, 32'h0000_0001, 1'b1};
    tbl[6] = '{1'b1, 5'd30, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4000_0000, 1'b1};
    tbl[7] = '{1'b0, 5'd0,  64'h0,                   32'h0,         1'b0};

    // Reset held two cycles with a write pending.
    drive(1'b0, 1'b1, 5'd1, 64'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "reset0");
    drive(1'b0, 1'b1, 5'd1, 64'hFF, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "reset1");

    // Single writes, XZR, same-address back-to-back, boundaries.
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, tbl[k].v, tbl[k].a, tbl[k].d, 1'b0, tbl[k].oh, tbl[k].done,
            1'b0, 1'b1, $sformatf("vec%0d", k));
    end

    // Sweep all addresses on consecutive cycles.
    for (int i = 0; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 64'(i) * 64'hac81, 1'b0,
            (i == 31) ? 32'h0 : (32'd1 << i), 1'b1, 1'b0, 1'b1,
            $sformatf("sweep%0d", i));
    end

    // Clear: 31 busy cycles; a repeated clear_req mid-sequence is ignored.
    drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, "clr_start");
    for (int k = 0; k < 31; k++) begin
      drive(1'b1, 1'b0, 5'd0, 64'h0, (k == 5), 32'd1 << k, 1'b0,
            (k != 30), (k == 30), $sformatf("clr%0d", k));
    end

    // Collision: write and clear on the same edge, then a write held in CLEAR.
    drive(1'b1, 1'b1, 5'd3, 64'd7, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 1'b0, "coll_start");
    for (int k = 0; k < 31; k++) begin
      drive(1'b1, 1'b1, 5'd9, 64'h99, 1'b0, 32'd1 << k, 1'b0,
            (k != 30), (k == 30), $sformatf("coll%0d", k));
    end
    drive(1'b1, 1'b1, 5'd9, 64'h99, 1'b0, 32'h0000_0200, 1'b1, 1'b0, 1'b1, "held_wr");

    // Reset at clear step 10.
    drive(1'b1, 1'b1, 5'd4, 64'h44, 1'b0, 32'h0000_0010, 1'b1, 1'b0, 1'b1, "pre_wr");
    drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b0, "mid_start");
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 32'd1 << k, 1'b0, 1'b1, 1'b0,
            $sformatf("mid%0d", k));
    end
    drive(1'b0, 1'b0, 5'd0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, "mid_reset");
    drive(1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, "post_reset");
    drive(1'b1, 1'b1, 5'd2, 64'h22, 1'b0, 32'h0000_0004, 1'b1, 1'b0, 1'b1, "post_wr");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
